// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - shared memory map constants and io-region decode helper
package mem_map_pkg;

    // Default RAM geometry: 17 byte-address bits, 128 KB.
    localparam int RAM_ADDR_WID_DEF = 17;
    localparam int RAM_SIZE         = 1 << RAM_ADDR_WID_DEF;

    // I/O window registers (18-bit decoded addresses).
    localparam logic [17:0] IO_BASE = 18'h30000;
    localparam logic [17:0] IO_UART = 18'h30000;
    localparam logic [17:0] IO_CLK  = 18'h30004;

    // Everything in 0x30000-0x3FFFF belongs to the I/O window.
    function automatic logic is_io(input logic [17:0] a);
        return a[17:16] == 2'b11;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - byte FIFO with same-cycle push-on-pop and drop reporting
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   push, push_data  write request and byte
//   pop              read request (ignored when empty)
//   head             byte at the read pointer
//   count            current occupancy
//   count_next       occupancy after this cycle's push/pop
//   full, empty      occupancy flags
//   dropped          push refused this cycle
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    output logic [7:0]                 head,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     count_next,
    output logic                       full,
    output logic                       empty,
    output logic                       dropped
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;
    logic          accept;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a byte when a slot frees up in the same cycle.
    assign accept  = push && (!full || do_pop);
    assign dropped = push && !accept;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({accept, do_pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - CPU byte-bus target: RAM, UART RX/TX, cycle counter, stop flag
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   rdy_in                bus qualifier; bus ignored while low
//   mem_a/mem_wr/mem_wdata CPU address, write select, write byte
//   mem_rdata             read byte, one cycle after the request
//   io_buffer_full        TX FIFO near full (registered)
//   rx_valid/rx_data      UART RX byte; rx_pop consumes it
//   tx_valid/tx_data      TX FIFO head; consumed when tx_ready
//   program_stop          sticky, set by write to 0x30004
//   tx_overflow           sticky, set when a TX byte is dropped
module mem_bus_responder
    import mem_map_pkg::*;
#(
    parameter int RAM_ADDR_WID = 17,
    parameter int TX_DEPTH     = 8,
    parameter int FULL_MARGIN  = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic        io_buffer_full,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        program_stop,
    output logic        tx_overflow
);

    localparam int CW = $clog2(TX_DEPTH) + 1;

    logic [7:0]              ram [2**RAM_ADDR_WID];
    logic [17:0]             addr;
    logic [RAM_ADDR_WID-1:0] ram_addr;
    logic                    io;
    logic                    rd_req;
    logic                    wr_req;
    logic [7:0]              rd_byte;
    logic [31:0]             counter;
    logic [31:0]             snapshot;

    logic                    tx_push;
    logic [7:0]              tx_push_data;
    logic [7:0]              fifo_head;
    logic [CW-1:0]           fifo_count;
    logic [CW-1:0]           fifo_count_next;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_dropped;
    logic                    unused_ok;

    assign unused_ok = ^{mem_a[31:18], fifo_count, fifo_full};

    assign addr     = mem_a[17:0];
    assign ram_addr = mem_a[RAM_ADDR_WID-1:0];
    assign io       = is_io(addr);
    assign rd_req   = rdy_in && !mem_wr;
    assign wr_req   = rdy_in && mem_wr;

    // RX consumption is combinational so the UART sees it in the request cycle.
    assign rx_pop = !rst_in && rd_req && io && (addr == IO_UART) && rx_valid;

    // Zero bytes on the UART port are filtered; the stop write injects a 0x00 marker.
    assign tx_push      = wr_req && io &&
                          (((addr == IO_UART) && (mem_wdata != 8'h00)) || (addr == IO_CLK));
    assign tx_push_data = (addr == IO_CLK) ? 8'h00 : mem_wdata;

    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_empty ? 8'h00 : fifo_head;

    byte_fifo #(
        .DEPTH(TX_DEPTH)
    ) u_tx_fifo (
        .clk        (clk_in),
        .rst        (rst_in),
        .push       (tx_push),
        .push_data  (tx_push_data),
        .pop        (tx_ready),
        .head       (fifo_head),
        .count      (fifo_count),
        .count_next (fifo_count_next),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .dropped    (fifo_dropped)
    );

    // Counter byte 0 is live; bytes 1-3 come from the snapshot taken by the
    // byte-0 read, so a multi-byte read sequence sees a consistent value.
    always_comb begin
        rd_byte = 8'h00;
        if (!io) begin
            rd_byte = ram[ram_addr];
        end else begin
            case (addr)
                IO_UART:          rd_byte = rx_valid ? rx_data : 8'h00;
                IO_CLK:           rd_byte = counter[7:0];
                IO_CLK + 18'd1:   rd_byte = snapshot[15:8];
                IO_CLK + 18'd2:   rd_byte = snapshot[23:16];
                IO_CLK + 18'd3:   rd_byte = snapshot[31:24];
                default:          rd_byte = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_req && !io) ram[ram_addr] <= mem_wdata;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_rdata      <= 8'h00;
            counter        <= '0;
            snapshot       <= '0;
            program_stop   <= 1'b0;
            tx_overflow    <= 1'b0;
            io_buffer_full <= 1'b0;
        end else begin
            if (rdy_in) counter <= counter + 32'd1;
            if (rd_req) mem_rdata <= rd_byte;
            if (rd_req && io && (addr == IO_CLK)) snapshot <= counter;
            if (wr_req && io && (addr == IO_CLK)) program_stop <= 1'b1;
            if (fifo_dropped) tx_overflow <= 1'b1;
            // Asserted early enough that the CPU, reacting a cycle late, cannot overflow.
            io_buffer_full <= (fifo_count_next >= CW'(TX_DEPTH - FULL_MARGIN));
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - directed self-checking bench for mem_bus_responder
module tb_mem_bus_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        io_buffer_full;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_pop;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        program_stop;
    logic        tx_overflow;

    int checks   = 0;
    int failures = 0;
    logic [7:0] txq[$];

    always #5 clk_in = ~clk_in;

    mem_bus_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .io_buffer_full (io_buffer_full),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_pop         (rx_pop),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .program_stop   (program_stop),
        .tx_overflow    (tx_overflow)
    );

    // Records every byte that will be handed over at the next rising edge.
    always begin
        @(negedge clk_in);
        #2;
        if (tx_valid === 1'b1 && tx_ready === 1'b1 && rst_in === 1'b0)
            txq.push_back(tx_data);
    end

    task automatic drive(input logic rdy, input logic wr, input logic [31:0] a, input logic [7:0] wd);
        @(negedge clk_in);
        rdy_in    = rdy;
        mem_wr    = wr;
        mem_a     = a;
        mem_wdata = wd;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic cyc(input logic rdy, input logic wr, input logic [31:0] a, input logic [7:0] wd);
        drive(rdy, wr, a, wd);
        tick();
    endtask

    task automatic reset_dut();
        @(negedge clk_in);
        rst_in = 1'b1;
        rdy_in = 1'b0;
        tick();
        tick();
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        rst_in = 1'b1; rdy_in = 1'b1; mem_wr = 1'b0; mem_a = 32'h30000;
        rx_valid = 1'b1; rx_data = 8'h55;
        #1;
        checks++; if (rx_pop !== 1'b0) begin failures++; $display("FAIL reset_rx_pop got=%0b exp=0", rx_pop); end
        tick(); tick();
        checks++; if (mem_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", mem_rdata); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%0b exp=0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (io_buffer_full !== 1'b0) begin failures++; $display("FAIL reset_ibf got=%0b exp=0", io_buffer_full); end
        checks++; if (program_stop !== 1'b0) begin failures++; $display("FAIL reset_stop got=%0b exp=0", program_stop); end
        checks++; if (tx_overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", tx_overflow); end
        @(negedge clk_in);
        rst_in = 1'b0; rdy_in = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic test_ram();
        reset_dut();
        cyc(1, 1, 32'h00010, 8'hA5);
        drive(1, 0, 32'h00010, 8'h00);
        #1;
        checks++; if (mem_rdata !== 8'h00) begin failures++; $display("FAIL ram_early got=%h exp=00", mem_rdata); end
        tick();
        checks++; if (mem_rdata !== 8'hA5) begin failures++; $display("FAIL ram_read got=%h exp=a5", mem_rdata); end
        cyc(1, 1, 32'h20010, 8'h3C);
        cyc(1, 0, 32'h00010, 8'h00);
        checks++; if (mem_rdata !== 8'h3C) begin failures++; $display("FAIL ram_alias got=%h exp=3c", mem_rdata); end
        cyc(1, 0, 32'h31000, 8'h00);
        checks++; if (mem_rdata !== 8'h00) begin failures++; $display("FAIL io_other got=%h exp=00", mem_rdata); end
        drive(0, 0, 32'h0, 8'h0);
    endtask

    task automatic test_tx_order();
        reset_dut();
        tx_ready = 1'b1;
        txq.delete();
        cyc(1, 1, 32'h30000, 8'h41);
        cyc(1, 1, 32'h30000, 8'h00);
        cyc(1, 1, 32'h30000, 8'h42);
        checks++; if (program_stop !== 1'b0) begin failures++; $display("FAIL stop_early got=%0b exp=0", program_stop); end
        cyc(1, 1, 32'h30004, 8'h99);
        checks++; if (program_stop !== 1'b1) begin failures++; $display("FAIL stop_set got=%0b exp=1", program_stop); end
        cyc(1, 1, 32'h30000, 8'h43);
        drive(0, 0, 32'h0, 8'h0);
        repeat (4) tick();
        checks++; if (txq.size() !== 4) begin failures++; $display("FAIL tx_count got=%0d exp=4", txq.size()); end
        else begin
            checks++; if (txq[0] !== 8'h41) begin failures++; $display("FAIL tx_b0 got=%h exp=41", txq[0]); end
            checks++; if (txq[1] !== 8'h42) begin failures++; $display("FAIL tx_b1 got=%h exp=42", txq[1]); end
            checks++; if (txq[2] !== 8'h00) begin failures++; $display("FAIL tx_b2 got=%h exp=00", txq[2]); end
            checks++; if (txq[3] !== 8'h43) begin failures++; $display("FAIL tx_b3 got=%h exp=43", txq[3]); end
        end
        checks++; if (program_stop !== 1'b1) begin failures++; $display("FAIL stop_sticky got=%0b exp=1", program_stop); end
    endtask

    task automatic test_rx();
        reset_dut();
        rx_valid = 1'b1; rx_data = 8'h37;
        drive(1, 0, 32'h30000, 8'h00);
        #1;
        checks++; if (rx_pop !== 1'b1) begin failures++; $display("FAIL rx_pop_hi got=%0b exp=1", rx_pop); end
        tick();
        checks++; if (mem_rdata !== 8'h37) begin failures++; $display("FAIL rx_data got=%h exp=37", mem_rdata); end
        drive(0, 0, 32'h0, 8'h00);
        #1;
        checks++; if (rx_pop !== 1'b0) begin failures++; $display("FAIL rx_pop_pulse got=%0b exp=0", rx_pop); end
        rx_valid = 1'b0;
        drive(1, 0, 32'h30000, 8'h00);
        #1;
        checks++; if (rx_pop !== 1'b0) begin failures++; $display("FAIL rx_pop_empty got=%0b exp=0", rx_pop); end
        tick();
        checks++; if (mem_rdata !== 8'h00) begin failures++; $display("FAIL rx_empty_data got=%h exp=00", mem_rdata); end
        drive(0, 0, 32'h0, 8'h00);
    endtask

    task automatic test_overflow();
        reset_dut();
        tx_ready = 1'b0;
        txq.delete();
        for (int i = 1; i <= 9; i++) begin
            cyc(1, 1, 32'h30000, 8'(i));
            if (i == 5) begin
                checks++; if (io_buffer_full !== 1'b0) begin failures++; $display("FAIL ibf_5 got=%0b exp=0", io_buffer_full); end
            end
            if (i == 6) begin
                checks++; if (io_buffer_full !== 1'b1) begin failures++; $display("FAIL ibf_6 got=%0b exp=1", io_buffer_full); end
            end
            if (i == 8) begin
                checks++; if (tx_overflow !== 1'b0) begin failures++; $display("FAIL ovf_8 got=%0b exp=0", tx_overflow); end
            end
            if (i == 9) begin
                checks++; if (tx_overflow !== 1'b1) begin failures++; $display("FAIL ovf_9 got=%0b exp=1", tx_overflow); end
            end
        end
        drive(0, 0, 32'h0, 8'h00);
        tx_ready = 1'b1;
        repeat (12) tick();
        checks++; if (txq.size() !== 8) begin failures++; $display("FAIL drain_count got=%0d exp=8", txq.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (txq[i] !== 8'(i + 1)) begin failures++; $display("FAIL drain_b%0d got=%h exp=%h", i, txq[i], 8'(i + 1)); end
            end
        end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0b exp=0", tx_valid); end
        checks++; if (io_buffer_full !== 1'b0) begin failures++; $display("FAIL drain_ibf got=%0b exp=0", io_buffer_full); end
        checks++; if (tx_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", tx_overflow); end
    endtask

    task automatic test_rdy_gating();
        reset_dut();
        cyc(1, 1, 32'h00020, 8'h11);
        cyc(1, 0, 32'h00020, 8'h00);
        checks++; if (mem_rdata !== 8'h11) begin failures++; $display("FAIL gate_pre got=%h exp=11", mem_rdata); end
        cyc(0, 1, 32'h00020, 8'h99);
        checks++; if (mem_rdata !== 8'h11) begin failures++; $display("FAIL gate_hold_wr got=%h exp=11", mem_rdata); end
        rx_valid = 1'b1; rx_data = 8'h77;
        drive(0, 0, 32'h30000, 8'h00);
        #1;
        checks++; if (rx_pop !== 1'b0) begin failures++; $display("FAIL gate_rx_pop got=%0b exp=0", rx_pop); end
        tick();
        checks++; if (mem_rdata !== 8'h11) begin failures++; $display("FAIL gate_hold_rd got=%h exp=11", mem_rdata); end
        repeat (3) tick();
        rx_valid = 1'b0;
        cyc(1, 0, 32'h30004, 8'h00);
        checks++; if (mem_rdata !== 8'h02) begin failures++; $display("FAIL gate_counter got=%h exp=02", mem_rdata); end
        cyc(1, 0, 32'h00020, 8'h00);
        checks++; if (mem_rdata !== 8'h11) begin failures++; $display("FAIL gate_ram got=%h exp=11", mem_rdata); end
        // Build up state, then reset in the middle of a read.
        tx_ready = 1'b0;
        cyc(1, 1, 32'h30000, 8'h5A);
        cyc(1, 1, 32'h30004, 8'h00);
        cyc(1, 0, 32'h00020, 8'h00);
        @(negedge clk_in);
        rst_in = 1'b1;
        tick();
        checks++; if (mem_rdata !== 8'h00) begin failures++; $display("FAIL mid_rdata got=%h exp=00", mem_rdata); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL mid_tx_valid got=%0b exp=0", tx_valid); end
        checks++; if (program_stop !== 1'b0) begin failures++; $display("FAIL mid_stop got=%0b exp=0", program_stop); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL mid_tx_data got=%h exp=00", tx_data); end
        checks++; if (rx_pop !== 1'b0) begin failures++; $display("FAIL mid_rx_pop got=%0b exp=0", rx_pop); end
        @(negedge clk_in);
        rst_in = 1'b0; rdy_in = 1'b0;
    endtask

    task automatic test_counter();
        reset_dut();
        repeat (32'h12345) cyc(1, 0, 32'h0, 8'h00);
        cyc(1, 0, 32'h30004, 8'h00);
        checks++; if (mem_rdata !== 8'h45) begin failures++; $display("FAIL cnt_b0 got=%h exp=45", mem_rdata); end
        cyc(1, 0, 32'h30005, 8'h00);
        checks++; if (mem_rdata !== 8'h23) begin failures++; $display("FAIL cnt_b1 got=%h exp=23", mem_rdata); end
        cyc(1, 0, 32'h30006, 8'h00);
        checks++; if (mem_rdata !== 8'h01) begin failures++; $display("FAIL cnt_b2 got=%h exp=01", mem_rdata); end
        cyc(1, 0, 32'h30007, 8'h00);
        checks++; if (mem_rdata !== 8'h00) begin failures++; $display("FAIL cnt_b3 got=%h exp=00", mem_rdata); end
        drive(0, 0, 32'h0, 8'h00);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b0; mem_a = '0; mem_wr = 1'b0; mem_wdata = '0;
        rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
        test_reset();
        test_ram();
        test_tx_order();
        test_rx();
        test_overflow();
        test_rdy_gating();
        test_counter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
